// File: rtl/restador_serial_top.sv
// rtl/restador_serial_top.sv - bit-serial LSB-first subtractor (data0 - data1), one bit per clock.
// Optional signed overflow output enabled by defining RESTADOR_SIGNED_OVF_EN.
module restador_serial_top #(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic [WIDTH-1:0] data0_i,
  input  logic [WIDTH-1:0] data1_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] result_o,
  output logic             borrow_o,
`ifdef RESTADOR_SIGNED_OVF_EN
  output logic             overflow_o,
`endif
  output logic             zero_o
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  state_e           state_q;
  logic [WIDTH-1:0] a_q, b_q, r_q;
  logic             br_q;
  logic [CNT_W-1:0] cnt_q;
  logic             busy_q, done_q, borrow_q, zero_q;
  logic [WIDTH-1:0] result_q;
`ifdef RESTADOR_SIGNED_OVF_EN
  logic             ovf_q;
`endif

  logic             bit_a, bit_b, diff_d, br_d;
  logic [WIDTH-1:0] r_d;
  logic             last_bit;

  always_comb begin
    bit_a    = a_q[0];
    bit_b    = b_q[0];
    diff_d   = bit_a ^ bit_b ^ br_q;
    br_d     = (~bit_a & bit_b) | (~(bit_a ^ bit_b) & br_q);
    r_d      = {diff_d, r_q[WIDTH-1:1]};
    last_bit = (cnt_q == CNT_W'(WIDTH - 1));
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      r_q      <= '0;
      br_q     <= 1'b0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
      borrow_q <= 1'b0;
      zero_q   <= 1'b1;
`ifdef RESTADOR_SIGNED_OVF_EN
      ovf_q    <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE, DONE: begin
          done_q <= 1'b0;
          if (start_i) begin
            a_q     <= data0_i;
            b_q     <= data1_i;
            br_q    <= 1'b0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= SHIFT;
          end else begin
            state_q <= IDLE;
          end
        end
        SHIFT: begin
          a_q   <= a_q >> 1;
          b_q   <= b_q >> 1;
          r_q   <= r_d;
          br_q  <= br_d;
          cnt_q <= cnt_q + 1'b1;
          if (last_bit) begin
            // In the last cycle the operand LSBs are the original MSBs.
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
            result_q <= r_d;
            borrow_q <= br_d;
            zero_q   <= (r_d == '0);
`ifdef RESTADOR_SIGNED_OVF_EN
            ovf_q    <= (bit_a ^ bit_b) & (bit_a ^ diff_d);
`endif
            state_q  <= DONE;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy_o   = busy_q;
  assign done_o   = done_q;
  assign result_o = result_q;
  assign borrow_o = borrow_q;
  assign zero_o   = zero_q;
`ifdef RESTADOR_SIGNED_OVF_EN
  assign overflow_o = ovf_q;
`endif

endmodule

// File: tb/tb_restador_serial_top.sv
// tb/tb_restador_serial_top.sv - scoreboard bench for restador_serial_top.
module tb_restador_serial_top;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] data0 = '0;
  logic [7:0] data1 = '0;
  logic       busy, done, borrow, zero;
  logic [7:0] result;
`ifdef RESTADOR_SIGNED_OVF_EN
  logic       ovf;
`else
  logic       ovf;
  assign ovf = 1'b0;
`endif

  int n_vec  = 0;
  int n_fail = 0;

  typedef struct {
    logic [7:0] res;
    logic       brw;
    logic       zro;
    logic       ovf;
    int         tag;
  } exp_t;

  exp_t exp_q[$];
  exp_t last_exp;

  always #5 clk = ~clk;

  restador_serial_top #(.WIDTH(8)) dut (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .start_i   (start),
    .data0_i   (data0),
    .data1_i   (data1),
    .busy_o    (busy),
    .done_o    (done),
    .result_o  (result),
    .borrow_o  (borrow),
`ifdef RESTADOR_SIGNED_OVF_EN
    .overflow_o(ovf),
`endif
    .zero_o    (zero)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic exp_t model(input logic [7:0] a, input logic [7:0] b, input int tag);
    exp_t e;
    e.res = a - b;
    e.brw = (a < b);
    e.zro = (e.res == 8'h00);
`ifdef RESTADOR_SIGNED_OVF_EN
    e.ovf = (a[7] != b[7]) && (e.res[7] != a[7]);
`else
    e.ovf = 1'b0;
`endif
    e.tag = tag;
    return e;
  endfunction

  always @(negedge clk) begin
    if (rst_n && done) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        last_exp = e;
        chk($sformatf("op%0d_result", e.tag), result, e.res);
        chk($sformatf("op%0d_borrow", e.tag), borrow, e.brw);
        chk($sformatf("op%0d_zero", e.tag), zero, e.zro);
`ifdef RESTADOR_SIGNED_OVF_EN
        chk($sformatf("op%0d_ovf", e.tag), ovf, e.ovf);
`endif
      end
    end
  end

  task automatic drive_start(input logic [7:0] a, input logic [7:0] b, input int tag, input bit push);
    start = 1'b1;
    data0 = a;
    data1 = b;
    if (push) exp_q.push_back(model(a, b, tag));
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(input bit check_lat);
    int n = 0;
    int bc = 0;
    do begin
      @(negedge clk);
      n++;
      if (busy) bc++;
    end while (!done && n < 40);
    chk("done_seen", done, 1'b1);
    if (check_lat) begin
      chk("start_to_done", n, 9);
      chk("busy_cycles", bc, 8);
    end
  endtask

  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input int tag);
    @(negedge clk);
    drive_start(a, b, tag, 1'b1);
    wait_done(1'b1);
  endtask

  initial begin
    int dn;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_result", result, 8'h00);
    chk("rst_borrow", borrow, 1'b0);
    chk("rst_zero", zero, 1'b1);
    chk("rst_ovf", ovf, 1'b0);
    rst_n = 1'b1;

    run_op(8'd200, 8'd55, 1);
    run_op(8'd10, 8'd20, 2);
    run_op(8'h80, 8'h01, 3);
    repeat (3) @(negedge clk);
    chk("held_result", result, last_exp.res);
    chk("held_borrow", borrow, last_exp.brw);

    // back-to-back: second start presented during the DONE cycle
    @(negedge clk);
    drive_start(8'h3C, 8'h3C, 4, 1'b1);
    wait_done(1'b0);
    drive_start(8'hFF, 8'h00, 5, 1'b1);
    wait_done(1'b1);

    // start pulses and operand changes while busy must be ignored
    @(negedge clk);
    drive_start(8'd77, 8'd33, 6, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      start = 1'b1;
      data0 = 8'($urandom);
      data1 = 8'($urandom);
      @(negedge clk);
      start = 1'b0;
    end
    wait_done(1'b0);

    // reset in the middle of an operation
    @(negedge clk);
    drive_start(8'd99, 8'd1, 7, 1'b0);
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_done", done, 1'b0);
    chk("midrst_result", result, 8'h00);
    chk("midrst_borrow", borrow, 1'b0);
    chk("midrst_zero", zero, 1'b1);
    chk("midrst_ovf", ovf, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    dn = 0;
    repeat (15) begin
      @(negedge clk);
      if (done) dn++;
    end
    chk("no_done_after_rst", dn, 0);
    run_op(8'd99, 8'd1, 8);

    for (int i = 0; i < 4; i++) begin
      run_op(8'($urandom), 8'($urandom), 9 + i);
    end
    run_op(8'h7F, 8'hFF, 13);

    repeat (2) @(negedge clk);
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
